i2c_bus_conditioner: RTL and testbench

Input conditioning stage that sits directly upstream of `i2c_if`, between the raw I2C pins and the I2C client's bit engine. It synchronises the asynchronous SCL/SDA pin levels into the `clk` domain and rejects glitches shorter than a programmable length. From the clean lines it produces single-cycle SCL edge, START and STOP event strobes, plus a bus-busy flag with a stuck-SCL timeout. `i2c_if` consumes only these outputs and never samples the pins directly.

---
 rtl/i2c_bus_conditioner.sv | 88 ++++++++
 tb/tb_i2c_bus_conditioner.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/i2c_bus_conditioner.sv
// i2c_bus_conditioner: synchronise and deglitch raw SCL/SDA, then decode edges, START/STOP and bus-busy with stuck-SCL timeout
//   clk, resetb              system clock, asynchronous active-low reset
//   scl_i, sda_i             raw asynchronous pin levels
//   scl_o, sda_o             filtered line levels
//   scl_rise_o, scl_fall_o   one-cycle filtered SCL edge strobes
//   start_o, stop_o          one-cycle START/repeated-START and STOP strobes
//   busy_o                   bus owned by a master
//   timeout_o                one-cycle strobe when SCL is held low too long while busy
module i2c_bus_conditioner #(
  parameter int          SYNC_STAGES = 2,
  parameter int          FILTER_LEN  = 4,
  parameter logic [23:0] TIMEOUT_CYC = 24'd1_000_000
) (
  input  logic clk,
  input  logic resetb,
  input  logic scl_i,
  input  logic sda_i,
  output logic scl_o,
  output logic sda_o,
  output logic scl_rise_o,
  output logic scl_fall_o,
  output logic start_o,
  output logic stop_o,
  output logic busy_o,
  output logic timeout_o
);
  typedef enum logic {IDLE, BUSY} state_t;
  localparam logic [3:0] FL_LAST = 4'(FILTER_LEN - 1);
  logic [1:0][SYNC_STAGES-1:0] sync_q;
  logic [1:0]                  line, f_q, f_d, fp_q;
  logic [1:0][3:0]             cnt_q, cnt_d;
  logic [23:0]                 to_cnt_q, to_cnt_d;
  state_t                      state_q, state_d;
  logic rise_q, rise_d, fall_q, fall_d, start_q, start_d, stop_q, stop_d, to_q, to_d, to_run;
  // index 0 is SCL, index 1 is SDA throughout
  always_comb begin
    line = {sync_q[1][SYNC_STAGES-1], sync_q[0][SYNC_STAGES-1]};
    for (int k = 0; k < 2; k++) begin
      f_d[k]   = (line[k] != f_q[k] && cnt_q[k] == FL_LAST) ? line[k] : f_q[k];
      cnt_d[k] = (line[k] == f_q[k] || cnt_q[k] == FL_LAST) ? 4'd0 : cnt_q[k] + 4'd1;
    end
    rise_d   = f_q[0] & ~fp_q[0];
    fall_d   = ~f_q[0] & fp_q[0];
    // requiring SCL high on both samples suppresses START/STOP when SCL moves in the same cycle
    start_d  = f_q[0] & fp_q[0] & fp_q[1] & ~f_q[1];
    stop_d   = f_q[0] & fp_q[0] & ~fp_q[1] & f_q[1];
    to_run   = (TIMEOUT_CYC != 24'd0) && (state_q == BUSY) && !f_q[0];
    to_d     = to_run && (to_cnt_q == TIMEOUT_CYC - 24'd1);
    to_cnt_d = (to_run && !to_d) ? to_cnt_q + 24'd1 : 24'd0;
    state_d  = start_d ? BUSY : (stop_d || to_d) ? IDLE : state_q;
  end
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      sync_q   <= '1;
      f_q      <= '1;
      fp_q     <= '1;
      cnt_q    <= '0;
      to_cnt_q <= '0;
      state_q  <= IDLE;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
      start_q  <= 1'b0;
      stop_q   <= 1'b0;
      to_q     <= 1'b0;
    end else begin
      sync_q[0] <= {sync_q[0][SYNC_STAGES-2:0], scl_i};
      sync_q[1] <= {sync_q[1][SYNC_STAGES-2:0], sda_i};
      f_q       <= f_d;
      fp_q      <= f_q;
      cnt_q     <= cnt_d;
      to_cnt_q  <= to_cnt_d;
      state_q   <= state_d;
      rise_q    <= rise_d;
      fall_q    <= fall_d;
      start_q   <= start_d;
      stop_q    <= stop_d;
      to_q      <= to_d;
    end
  end
  assign scl_o      = f_q[0];
  assign sda_o      = f_q[1];
  assign scl_rise_o = rise_q;
  assign scl_fall_o = fall_q;
  assign start_o    = start_q;
  assign stop_o     = stop_q;
  assign busy_o     = (state_q == BUSY);
  assign timeout_o  = to_q;
endmodule

// File: tb/tb_i2c_bus_conditioner.sv
// tb_i2c_bus_conditioner: scoreboard bench comparing the conditioner against a sample-window reference model
module tb_i2c_bus_conditioner;
  localparam int S  = 2;
  localparam int F  = 4;
  localparam int TO = 100;
  logic clk = 1'b0, resetb = 1'b0, scl_pin = 1'b0, sda_pin = 1'b0;
  logic scl_o, sda_o, scl_rise_o, scl_fall_o, start_o, stop_o, busy_o, timeout_o;
  int   errors = 0, checks = 0, edge_n = 0;
  int   n_start = 0, n_to = 0, d_start = 0, d_to = 0;
  logic [7:0] exp_q[$];
  logic ps[$], pd[$], ws[$], wd[$];
  logic mf_s, mf_d, mfp_s, mfp_d, mbusy;
  int   mrun;
  localparam logic [7:0] RST_V = 8'b1100_0000;

  i2c_bus_conditioner #(.SYNC_STAGES(S), .FILTER_LEN(F), .TIMEOUT_CYC(24'(TO))) dut (
    .clk(clk), .resetb(resetb), .scl_i(scl_pin), .sda_i(sda_pin),
    .scl_o(scl_o), .sda_o(sda_o), .scl_rise_o(scl_rise_o), .scl_fall_o(scl_fall_o),
    .start_o(start_o), .stop_o(stop_o), .busy_o(busy_o), .timeout_o(timeout_o));

  always #5 clk = ~clk;

  function automatic logic flips(input logic w[$], input logic f);
    if (w.size() != F) return 1'b0;
    foreach (w[i]) if (w[i] == f) return 1'b0;
    return 1'b1;
  endfunction

  task automatic m_reset();
    ps = '{}; pd = '{}; ws = '{}; wd = '{};
    for (int i = 0; i < S; i++) begin ps.push_back(1'b1); pd.push_back(1'b1); end
    mf_s = 1'b1; mf_d = 1'b1; mfp_s = 1'b1; mfp_d = 1'b1; mbusy = 1'b0; mrun = 0;
  endtask

  // one clock edge of the reference: pins pass through an S-deep delay, a level is accepted once
  // the last F delayed samples all disagree with it, and events come from the last two accepted levels
  task automatic m_step(input logic s, input logic d);
    logic ns, nd, rise, fall, st, sp, to;
    ps.push_back(s); pd.push_back(d);
    ws.push_back(ps.pop_front()); wd.push_back(pd.pop_front());
    if (ws.size() > F) void'(ws.pop_front());
    if (wd.size() > F) void'(wd.pop_front());
    ns = flips(ws, mf_s) ? ~mf_s : mf_s;
    nd = flips(wd, mf_d) ? ~mf_d : mf_d;
    rise = mf_s & ~mfp_s;
    fall = ~mf_s & mfp_s;
    st = mf_s & mfp_s & mfp_d & ~mf_d;
    sp = mf_s & mfp_s & ~mfp_d & mf_d;
    to = 1'b0;
    if (mbusy && !mf_s) begin
      mrun++;
      if (mrun == TO) begin to = 1'b1; mrun = 0; end
    end else mrun = 0;
    if (st) mbusy = 1'b1;
    else if (sp || to) mbusy = 1'b0;
    n_start += int'(st); n_to += int'(to);
    mfp_s = mf_s; mfp_d = mf_d; mf_s = ns; mf_d = nd;
    exp_q.push_back({ns, nd, rise, fall, st, sp, mbusy, to});
  endtask

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s edge=%0d got=%b want=%b (scl sda rise fall start stop busy timeout)", name, edge_n, got, want);
    end
  endtask

  always @(posedge clk) edge_n++;

  always @(negedge clk) begin
    if (start_o) d_start++;
    if (timeout_o) d_to++;
    if (exp_q.size() > 0)
      chk("outputs", {scl_o, sda_o, scl_rise_o, scl_fall_o, start_o, stop_o, busy_o, timeout_o}, exp_q.pop_front());
  end

  task automatic hold(input logic s, input logic d, input int n);
    for (int i = 0; i < n; i++) begin
      scl_pin = s; sda_pin = d;
      @(posedge clk);
      m_step(s, d);
      #1;
    end
  endtask

  task automatic reset_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      exp_q.push_back(RST_V);
      #1;
    end
    resetb = 1'b1;
  endtask

  task automatic mid_reset();
    @(negedge clk);
    #1 resetb = 1'b0;
    #1 chk("async_reset", {scl_o, sda_o, scl_rise_o, scl_fall_o, start_o, stop_o, busy_o, timeout_o}, RST_V);
    m_reset();
    reset_cycles(3);
  endtask

  task automatic frame();
    hold(1'b1, 1'b1, 8);
    hold(1'b1, 1'b0, 8);
    for (int b = 0; b < 9; b++) begin
      logic v;
      v = 1'($urandom_range(0, 1));
      hold(1'b0, v, $urandom_range(5, 9));
      hold(1'b1, v, $urandom_range(5, 9));
    end
    hold(1'b0, 1'b0, 6);
    hold(1'b1, 1'b0, 6);
    hold(1'b1, 1'b1, 8);
  endtask

  initial begin
    m_reset();
    repeat (3) begin @(posedge clk); exp_q.push_back(RST_V); end
    #1 chk("reset_hold", {scl_o, sda_o, scl_rise_o, scl_fall_o, start_o, stop_o, busy_o, timeout_o}, RST_V);
    resetb = 1'b1;
    hold(1'b0, 1'b0, 12);
    hold(1'b1, 1'b1, 12);
    hold(1'b0, 1'b1, 3);
    hold(1'b1, 1'b1, 12);
    hold(1'b0, 1'b1, 4);
    hold(1'b1, 1'b1, 12);
    hold(1'b1, 1'b0, 12);
    hold(1'b1, 1'b1, 12);
    hold(1'b0, 1'b0, 12);
    hold(1'b1, 1'b1, 12);
    hold(1'b1, 1'b0, 10);
    hold(1'b0, 1'b0, TO);
    hold(1'b1, 1'b0, 10);
    hold(1'b1, 1'b1, 12);
    hold(1'b1, 1'b0, 10);
    hold(1'b0, 1'b0, TO - 1);
    hold(1'b1, 1'b0, 10);
    hold(1'b1, 1'b1, 12);
    hold(1'b1, 1'b0, 10);
    hold(1'b0, 1'b0, 10);
    mid_reset();
    hold(1'b0, 1'b0, 12);
    hold(1'b1, 1'b1, 12);
    repeat (20) frame();
    for (int i = 0; i < 300; i++)
      hold(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(1, 8));
    repeat (5) frame();
    hold(1'b1, 1'b1, 10);
    checks++;
    if (d_start != n_start) begin errors++; $display("FAIL start_count got=%0d want=%0d", d_start, n_start); end
    checks++;
    if (d_to != n_to) begin errors++; $display("FAIL timeout_count got=%0d want=%0d", d_to, n_to); end
    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL queue_drain got=%0d want=0", exp_q.size()); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
